// File: rtl/full_adder.sv
// Ripple-carry full adder built from WIDTH one-bit cells, with optional output register.
// REG_OUT=1 gives a 1-cycle latency pipeline stage; REG_OUT=0 is a pure combinational path.
module full_adder #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  logic [WIDTH:0]   cy;
  logic [WIDTH-1:0] sum_d;

  assign cy[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum_d[i]  = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1]   = (a[i] & b[i]) | (a[i] & cy[i]) | (b[i] & cy[i]);
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             valid_q;

    // Result holds while in_valid is low; only out_valid drops.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        if (in_valid) begin
          sum_q   <= sum_d;
          carry_q <= cy[WIDTH];
        end
        valid_q <= in_valid;
      end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk, rst};

    assign sum       = sum_d;
    assign carry     = cy[WIDTH];
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: four instances (1/4/8-bit registered, 1-bit combinational)
// checked every cycle against an arithmetic model plus directed literal expectations.
module tb_full_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       s1, co1, ov1;
  logic       v4 = 1'b0, c4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic       co4, ov4;
  logic       v8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       co8, ov8;
  logic       v0 = 1'b0, a0 = 1'b0, b0 = 1'b0, c0 = 1'b0;
  logic       s0, co0, ov0;

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c(c1),
    .sum(s1), .carry(co1), .out_valid(ov1));
  full_adder #(.WIDTH(4), .REG_OUT(1'b1)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .c(c4),
    .sum(s4), .carry(co4), .out_valid(ov4));
  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c(c8),
    .sum(s8), .carry(co8), .out_valid(ov8));
  full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .a(a0), .b(b0), .c(c0),
    .sum(s0), .carry(co0), .out_valid(ov0));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {carry,sum} for {a,b,c} = 0..7
  localparam logic [1:0] TT [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  // Model: registered result = a+b+c of last accepted operands, cleared by reset.
  bit         model_live = 1'b0;
  logic [1:0] exp1;  logic ev1;
  logic [4:0] exp4;  logic ev4;
  logic [8:0] exp8;  logic ev8;

  always @(posedge clk) begin
    if (rst) begin
      model_live = 1'b1;
      exp1 = '0; exp4 = '0; exp8 = '0;
      ev1 = 1'b0; ev4 = 1'b0; ev8 = 1'b0;
    end else begin
      if (v1) exp1 = 2'(a1) + 2'(b1) + 2'(c1);
      if (v4) exp4 = 5'(a4) + 5'(b4) + 5'(c4);
      if (v8) exp8 = 9'(a8) + 9'(b8) + 9'(c8);
      ev1 = v1; ev4 = v4; ev8 = v8;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("w1_result", {co1, s1}, exp1);
      chk("w1_valid", ov1, ev1);
      chk("w4_result", {co4, s4}, exp4);
      chk("w4_valid", ov4, ev4);
      chk("w8_result", {co8, s8}, exp8);
      chk("w8_valid", ov8, ev8);
      chk("comb_result", {co0, s0}, 2'(a0) + 2'(b0) + 2'(c0));
      chk("comb_valid", ov0, v0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(); step();
    rst = 1'b0;

    // Exhaustive 1-bit sweep
    v1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = 3'(i);
      step();
      chk("sweep_result", {co1, s1}, TT[i]);
      chk("sweep_valid", ov1, 1'b1);
    end

    // Reset wins over in_valid
    rst = 1'b1; {a1, b1, c1} = 3'b111; v1 = 1'b1;
    step();
    chk("rst_result_c1", {co1, s1, ov1}, 3'b000);
    step();
    chk("rst_result_c2", {co1, s1, ov1}, 3'b000);
    rst = 1'b0;
    step();
    chk("post_rst_result", {co1, s1}, 2'b11);
    chk("post_rst_valid", ov1, 1'b1);

    // Hold on in_valid low
    {a1, b1, c1} = 3'b011; v1 = 1'b1;
    step();
    chk("hold_load", {co1, s1, ov1}, 3'b101);
    {a1, b1, c1} = 3'b100; v1 = 1'b0;
    step();
    chk("hold_keep", {co1, s1}, 2'b10);
    chk("hold_valid", ov1, 1'b0);

    // 4-bit directed
    v4 = 1'b1; a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
    step();
    chk("w4_f_0_1", {co4, s4}, 5'h10);
    a4 = 4'h7; b4 = 4'h8; c4 = 1'b0;
    step();
    chk("w4_7_8_0", {co4, s4}, 5'h0F);
    a4 = 4'hA; b4 = 4'h5; c4 = 1'b1;
    step();
    chk("w4_a_5_1", {co4, s4}, 5'h10);
    v4 = 1'b0;

    // 8-bit: pinned vectors then random back-to-back
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; c8 = 1'b1;
    step();
    chk("w8_ff_01_1", {co8, s8}, 9'h101);
    a8 = 8'h80; b8 = 8'h7F; c8 = 1'b0;
    step();
    chk("w8_80_7f_0", {co8, s8}, 9'h0FF);
    for (int n = 0; n < 1000; n++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      if (n == 500) rst = 1'b1;
      step();
      if (n == 500) begin
        chk("w8_midrst", {co8, s8, ov8}, 10'h000);
        rst = 1'b0;
      end
    end
    v8 = 1'b0;
    step();
    chk("w8_idle_valid", ov8, 1'b0);

    // Combinational instance: c every 50ns, b every 100ns, a every 200ns
    v0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {a0, b0, c0} = 3'(i);
      #25;
      chk("comb_tt", {co0, s0}, TT[i]);
      chk("comb_tt_valid", ov0, 1'b1);
      #25;
    end
    v0 = 1'b0;
    #1;
    chk("comb_valid_low", ov0, 1'b0);

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
